// File: rtl/rotate_step_sequencer_16bit.sv
// rtl/rotate_step_sequencer_16bit.sv - pattern/amount sequencer feeding the 16-bit rotate stages (optional BOUNCE_EN ping-pong sweep)
module rotate_step_sequencer_16bit #(
    parameter int TICK_DIV = 5_000_000,
    parameter int N_PASS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] pat_in,
    input  logic        start,
    input  logic        stop,
    input  logic        dir_in,
    output logic [15:0] a,
    output logic [3:0]  amt,
    output logic        dir,
    output logic        busy,
    output logic        done_tick,
    output logic [7:0]  pass_cnt
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [7:0]    pass_next;
    logic          pass_hit;

    // Saturating revolution count and the programmed-end test for the wrap step.
    assign pass_next = (pass_cnt == 8'hFF) ? 8'hFF : pass_cnt + 8'd1;
    assign pass_hit  = (N_PASS != 0) && ({24'd0, pass_next} == N_PASS);

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prescaler <= '0;
            a         <= 16'd0;
            amt       <= 4'd0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            pass_cnt  <= 8'd0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                S_RUN: begin
                    if (stop) begin
                        state <= S_PAUSE;
                    end else if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        amt       <= amt + 4'd1;
                        if (amt == 4'd15) begin
                            pass_cnt <= pass_next;
`ifdef BOUNCE_EN
                            dir <= ~dir;
`endif
                            if (pass_hit) begin
                                state     <= S_DONE;
                                done_tick <= 1'b1;
                                busy      <= 1'b0;
                                amt       <= 4'd0;
                            end
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        amt   <= 4'd0;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    // IDLE and DONE behave alike; a same-cycle load feeds the new run.
                    if (load) begin
                        a   <= pat_in;
                        amt <= 4'd0;
                    end
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        dir       <= dir_in;
                        prescaler <= '0;
                        pass_cnt  <= 8'd0;
                        amt       <= 4'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_step_sequencer_16bit.sv
// tb/tb_rotate_step_sequencer_16bit.sv - randomized self-checking bench for rotate_step_sequencer_16bit
module tb_rotate_step_sequencer_16bit;

    localparam int TD = 2;
    localparam int NP = 2;
`ifdef BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] pat_in = 16'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir_in = 1'b0;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        dir;
    logic        busy;
    logic        done_tick;
    logic [7:0]  pass_cnt;

    int total = 0;
    int bad = 0;

    rotate_step_sequencer_16bit #(.TICK_DIV(TD), .N_PASS(NP)) dut (
        .clk(clk), .reset(reset), .load(load), .pat_in(pat_in),
        .start(start), .stop(stop), .dir_in(dir_in),
        .a(a), .amt(amt), .dir(dir), .busy(busy),
        .done_tick(done_tick), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a run is described by the number of un-paused RUN cycles since start.
    int m_state = 0;  // 0 idle, 1 run, 2 pause, 3 done
    int m_rc = 0;
    int m_pass_hold = 0;
    int m_dir0 = 0;
    int m_a = 0;
    int m_done = 0;

    function automatic int m_cur_pass();
        int p;
        p = m_rc / TD / 16;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic model_edge();
        m_done = 0;
        if (reset) begin
            m_state = 0; m_rc = 0; m_pass_hold = 0; m_dir0 = 0; m_a = 0;
        end else begin
            case (m_state)
                1: begin
                    if (stop) m_state = 2;
                    else begin
                        m_rc++;
                        if (NP != 0 && m_rc % (16 * TD) == 0 && m_rc / (16 * TD) == NP) begin
                            m_state = 3; m_pass_hold = NP; m_done = 1;
                        end
                    end
                end
                2: begin
                    if (stop) begin
                        m_pass_hold = m_cur_pass(); m_state = 0;
                    end else if (start) m_state = 1;
                end
                default: begin
                    if (load) m_a = int'(pat_in);
                    if (start) begin
                        m_state = 1; m_rc = 0; m_dir0 = int'(dir_in);
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int e_busy, e_amt, e_pass, e_dir;
        e_busy = (m_state == 1 || m_state == 2) ? 1 : 0;
        e_amt  = e_busy ? (m_rc / TD) % 16 : 0;
        e_pass = e_busy ? m_cur_pass() : m_pass_hold;
        e_dir  = m_dir0 ^ (BOUNCE ? (e_pass & 1) : 0);
        check("a", 32'(a), 32'(m_a));
        check("amt", 32'(amt), 32'(e_amt));
        check("dir", 32'(dir), 32'(e_dir));
        check("busy", 32'(busy), 32'(e_busy));
        check("done_tick", 32'(done_tick), 32'(m_done));
        check("pass_cnt", 32'(pass_cnt), 32'(e_pass));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    int nticks;

    initial begin
        // Reset for two cycles.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("rst_a", 32'(a), 32'h0);
        check("rst_amt", 32'(amt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pass", 32'(pass_cnt), 32'h0);

        // Load then start a right-rotate run.
        load = 1'b1; pat_in = 16'h8001; step(); load = 1'b0;
        start = 1'b1; dir_in = 1'b0; step(); start = 1'b0;
        check("run_busy", 32'(busy), 32'h1);
        check("run_dir", 32'(dir), 32'h0);
        repeat (10) step();
        check("amt_at_5", 32'(amt), 32'h5);

        // Pause for 20 cycles, then resume.
        stop = 1'b1; step(); stop = 1'b0;
        repeat (20) step();
        check("pause_amt", 32'(amt), 32'h5);
        check("pause_busy", 32'(busy), 32'h1);
        start = 1'b1; step(); start = 1'b0;
        repeat (2) step();
        check("resume_amt", 32'(amt), 32'h6);

        // Load during RUN is ignored.
        load = 1'b1; pat_in = 16'hFFFF; step(); load = 1'b0;
        check("run_load_ign", 32'(a), 32'h8001);

        // Run to completion; done_tick must pulse exactly once.
        nticks = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_tick) nticks++;
            if (!busy) break;
        end
        check("done_busy", 32'(busy), 32'h0);
        check("done_ticks", 32'(nticks), 32'h1);
        check("done_pass", 32'(pass_cnt), 32'(NP));
        repeat (3) step();
        check("done_hold", 32'(pass_cnt), 32'(NP));

        // Load+start in DONE uses the new pattern.
        load = 1'b1; start = 1'b1; pat_in = 16'hFFFF; dir_in = 1'b1; step();
        load = 1'b0; start = 1'b0;
        check("ls_a", 32'(a), 32'hFFFF);
        check("ls_busy", 32'(busy), 32'h1);
        check("ls_dir", 32'(dir), 32'h1);
        repeat (18) step();
        check("amt_at_9", 32'(amt), 32'h9);

        // Reset mid-run.
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_a", 32'(a), 32'h0);
        check("mid_rst_amt", 32'(amt), 32'h0);
        check("mid_rst_dir", 32'(dir), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_pass", 32'(pass_cnt), 32'h0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom % 500) == 0;
            load   = ($urandom % 10) == 0;
            start  = ($urandom % 8) == 0;
            stop   = ($urandom % 40) == 0;
            dir_in = 1'($urandom);
            pat_in = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
